shift_deserializer: RTL
=======================

# shift_deserializer

Serial-to-parallel receiver for the bit streams produced by the universal shift register blocks in the datapath. It samples one serial bit per enabled clock, in either MSB-first (left-shift) or LSB-first (right-shift) order, and reassembles WIDTH-bit words. Completed words go into a one-entry holding register and are handed off over a valid/ready handshake, with sticky overflow detection. It sits at the receiving end of a serial link fed by the shift register's `sli`/`sri` chain.

## Interface
- WIDTH, 8, word length in bits (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- enb  input  1  shift enable; `sin` is sampled on each clk edge where enb=1
- dir  input  1  bit order: 1 = MSB first (left shift), 0 = LSB first (right shift)
- sin  input  1  serial data in
- clr  input  1  synchronous abort of the partial frame; also clears ovf
- out  output  WIDTH  assembled word (holding register)
- out_valid  output  1  holding register contains an unconsumed word
- out_ready  input  1  consumer accepts `out` on an edge where out_valid=1
- busy  output  1  partial frame in progress (bit_cnt≠0)
- bit_cnt  output  $clog2(WIDTH)  bits received in the current frame
- ovf  output  1  sticky: a completed word was dropped

## Operation
- Shift register `sh` (WIDTH bits), bit counter `bit_cnt`, latched order bit `dir_q`, holding register `out`.
- Frame start: on the first enb edge with bit_cnt=0, `dir_q` is loaded from dir. Later bits of the frame use `dir_q`. A dir change mid-frame is ignored until the next frame.
- Shift on enb:
  - MSB first: sh ← {sh[WIDTH-2:0], sin}.
  - LSB first: sh ← {sin, sh[WIDTH-1:1]}.
  - bit_cnt increments by 1.
- Completion: an enb edge with bit_cnt=WIDTH-1. The assembled word includes the current `sin`. bit_cnt wraps to 0 and the next enb edge starts a new frame. The word is computed combinationally from sh and sin, so there is no dead cycle.
- Holding register at a completion edge:
  - out_valid=0, or out_valid=1 with out_ready=1: load out with the new word; out_valid=1.
  - out_valid=1 with out_ready=0: drop the new word. `out` is unchanged and ovf←1.
- Handshake: a transfer occurs on an edge with out_valid=1 and out_ready=1. Without a simultaneous completion, out_valid←0. `out` keeps its last value after the transfer.
- clr=1: sh←0, bit_cnt←0, ovf←0. clr has priority over enb. The holding register and out_valid are unaffected, and a handshake in the same cycle still completes.
- busy = (bit_cnt≠0), combinational from the register.
- enb=0: sh, bit_cnt and dir_q hold. Handshake still operates.

## Timing
- Reset (rst_n=0, async, immediate): out=0, out_valid=0, ovf=0, bit_cnt=0, busy=0, sh=0, dir_q=0.
- Reset mid-frame discards the partial word and any held word.
- Latency: out and out_valid are updated at the same edge that samples the WIDTH-th bit, so they are visible in the following cycle.
- Throughput: one word per WIDTH enb cycles, continuous, with no bubbles, provided out_ready=1.
- out_valid stays high until accepted. out is stable while out_valid=1, except when it is reloaded at a completion edge coinciding with a transfer.
- ovf is set at the drop edge and stays 1 until clr or reset.
- All outputs are registered except busy, which is derived from the bit_cnt register.

## Test plan
- Reset: drive garbage with rst_n=0, then release -> out=0x00, out_valid=0, ovf=0, bit_cnt=0, busy=0. Assert rst_n low after 3 bits -> bit_cnt=0 immediately. A fresh 8-bit frame then decodes correctly.
- MSB first, dir=1, enb=1, out_ready=1, sin=1,0,0,1,0,1,1,0 on consecutive edges -> out=0x96, out_valid high for exactly one cycle after the 8th edge. busy is high after bits 1–7.
- LSB first with gaps: dir=0, sin=0,1,1,1,1,0,0,0 with enb low for 2 cycles between each bit -> out=0x1E. bit_cnt holds through the gaps. Toggling dir after bit 3 does not change the result.
- Overflow: out_ready=0, send 0x11 then 0x22 MSB first -> out=0x11, out_valid=1, ovf=1 after the 16th bit. Raising out_ready for 1 cycle transfers 0x11, then out_valid=0. Pulsing clr -> ovf=0.
- Back-to-back: hold 0x11 unaccepted, then assert out_ready exactly on the completion edge of 0x22 -> 0x11 transfers, out=0x22, out_valid stays 1, ovf=0.
- clr mid-frame: after 5 bits, clr=1 together with enb=1 -> bit_cnt=0 and the bit is discarded. The next 8 bits decode as a fresh word, and a held word stays valid throughout.

Source files
------------

// File: rtl/shift_deserializer.sv
// shift_deserializer
//
// Serial-to-parallel receiver. One serial bit is taken on every clock edge
// where enb=1. The bit order is chosen per frame, and completed WIDTH-bit
// words are placed in a one-entry holding register that is drained over a
// valid/ready handshake. If a completed word arrives while the holding
// register is still full and not being drained, the new word is dropped and
// a sticky overflow flag is set.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   enb       shift enable; sin is sampled on each enabled edge
//   dir       bit order: 1 = MSB first, 0 = LSB first (latched at frame start)
//   sin       serial data in
//   clr       synchronous abort of the partial frame; also clears ovf
//   out       assembled word (holding register)
//   out_valid holding register contains an unconsumed word
//   out_ready consumer accepts out on an edge where out_valid=1
//   busy      partial frame in progress (bit_cnt != 0)
//   bit_cnt   bits received in the current frame
//   ovf       sticky: a completed word was dropped
module shift_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enb,
  input  logic                     dir,
  input  logic                     sin,
  input  logic                     clr,
  output logic [WIDTH-1:0]         out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic                     ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             ovf_q, ovf_d;

  logic             eff_dir;
  logic [WIDTH-1:0] shifted;
  logic             complete;
  logic             transfer;

  always_comb begin
    sh_d        = sh_q;
    bit_cnt_d   = bit_cnt_q;
    dir_d       = dir_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    ovf_d       = ovf_q;

    // The first bit of a frame uses the live dir input; the rest of the
    // frame follows the order latched on that first bit.
    eff_dir  = (bit_cnt_q == '0) ? dir : dir_q;
    shifted  = eff_dir ? {sh_q[WIDTH-2:0], sin} : {sin, sh_q[WIDTH-1:1]};
    complete = enb && !clr && (bit_cnt_q == LAST_BIT);
    transfer = out_valid_q && out_ready;

    if (clr) begin
      sh_d      = '0;
      bit_cnt_d = '0;
      ovf_d     = 1'b0;
    end else if (enb) begin
      sh_d  = shifted;
      dir_d = eff_dir;
      if (complete) begin
        bit_cnt_d = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end

    // A transfer empties the holding register unless a completed word
    // refills it on the same edge; a completion into a full, stalled
    // register is dropped and flagged.
    if (transfer) begin
      out_valid_d = 1'b0;
    end
    if (complete) begin
      if (!out_valid_q || out_ready) begin
        out_d       = shifted;
        out_valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q        <= '0;
      bit_cnt_q   <= '0;
      dir_q       <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      sh_q        <= sh_d;
      bit_cnt_q   <= bit_cnt_d;
      dir_q       <= dir_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;
  assign bit_cnt   = bit_cnt_q;
  assign busy      = (bit_cnt_q != '0);

endmodule
